// File: rtl/uart_pkg.sv
// Shared UART definitions: byte/counter widths, TX arbiter state encoding,
// and a saturating counter helper used by the RX and TX blocks.
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set-bit selector: scans req upward from ptr with wrap
// and returns a one-hot grant plus a flag saying anything was found.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Walk the N positions starting at ptr; the first asserted one wins.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        sum = '0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte serializer between NREQ requesters. Round-robin
// grant, locked to the owner until its last byte, a burst limit, or an
// idle timeout; the serializer is driven via a start pulse and busy.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [BYTE_W*NREQ-1:0] i_req_data,
    input  logic [NREQ-1:0]        i_req_last,
    output logic [NREQ-1:0]        o_req_ready,
    output logic [NREQ-1:0]        o_grant,
    output logic                   o_tx_start,
    output logic [BYTE_W-1:0]      o_tx_data,
    input  logic                   i_tx_busy
);

    localparam int PTR_W = $clog2(NREQ);

    tx_state_e          state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic [CNT_W-1:0]   tout_q, tout_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               last_q, last_d;

    logic [NREQ-1:0]    pick_gnt;
    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;
    logic               own_valid;
    logic               own_last;
    logic [BYTE_W-1:0]  own_data;
    logic               rel;

    rr_pick #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (i_req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // Encode the one-hot pick as an index so the owner can advance the pointer.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    // Mux the owner's request lines; grant_q is one-hot or zero.
    always_comb begin
        own_data  = '0;
        own_valid = |(i_req_valid & grant_q);
        own_last  = |(i_req_last & grant_q);
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q[k]) begin
                own_data = i_req_data[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Next-state and counters; a release always lands in IDLE with no grant.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        burst_d   = burst_q;
        tout_d    = tout_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        rel       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                    burst_d = '0;
                    tout_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (own_valid && !i_tx_busy) begin
                    tx_data_d = own_data;
                    last_d    = own_last;
                    burst_d   = sat_inc(burst_q);
                    tout_d    = '0;
                    state_d   = START;
                end else if (!own_valid) begin
                    tout_d = sat_inc(tout_q);
                    if (tout_d == CNT_W'(HOLD_TIMEOUT)) begin
                        rel = 1'b1;
                    end
                end
            end
            START: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (last_q || (burst_q == CNT_W'(MAX_BURST))) begin
                        rel = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (rel) begin
            grant_d  = '0;
            rr_ptr_d = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);
            state_d  = IDLE;
        end
    end

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            burst_q   <= '0;
            tout_q    <= '0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            burst_q   <= burst_d;
            tout_q    <= tout_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = (state_q == START);
    assign o_req_ready = ((state_q == SEND) && !i_tx_busy) ? (i_req_valid & grant_q) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NREQ=4, MAX_BURST=4, HOLD_TIMEOUT=5.
// Byte sources and a serializer model run alongside the directed sequence.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  o_req_ready;
    logic [3:0]  o_grant;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        tx_busy = 1'b0;

    logic [8:0]  src_q [4][$];
    logic [11:0] log_q [$];
    logic [11:0] exp_q [$];
    logic [3:0]  fire_s = '0;
    logic        force_b = 1'b0;
    logic        mdl_busy = 1'b0;
    logic        start_prev = 1'b0;
    int          mdl_cnt = 0;
    int          total = 0;
    int          bad = 0;

    uart_tx_arbiter #(
        .NREQ         (4),
        .MAX_BURST    (4),
        .HOLD_TIMEOUT (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .i_tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    // Handshake sample and transmit log, taken mid-cycle.
    always @(negedge clk) begin
        fire_s = req_valid & o_req_ready;
        if (o_tx_start) log_q.push_back({o_grant, o_tx_data});
    end

    // Byte sources: pop on an accepted transfer, present the queue head.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            if (fire_s[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            if (src_q[k].size() > 0) begin
                req_valid[k]         = 1'b1;
                req_data[k*8 +: 8]   = src_q[k][0][7:0];
                req_last[k]          = src_q[k][0][8];
            end else begin
                req_valid[k]         = 1'b0;
                req_data[k*8 +: 8]   = 8'h00;
                req_last[k]          = 1'b0;
            end
        end
    end

    // Serializer: busy rises one cycle after start and stays high 10 cycles.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            mdl_busy   = 1'b0;
            mdl_cnt    = 0;
            start_prev = 1'b0;
        end else begin
            if (mdl_cnt > 0) begin
                mdl_cnt = mdl_cnt - 1;
                if (mdl_cnt == 0) mdl_busy = 1'b0;
            end
            if (start_prev) begin
                mdl_busy = 1'b1;
                mdl_cnt  = 10;
            end
            start_prev = o_tx_start;
        end
        tx_busy = mdl_busy | force_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input logic [3:0] g, input int budget, input string tag);
        int n;
        n = 0;
        while (o_grant !== g && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(o_grant), 32'(g));
    endtask

    task automatic wait_busy(input logic v, input int budget, input string tag);
        int n;
        n = 0;
        while (tx_busy !== v && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(tx_busy), 32'(v));
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, (i < log_q.size()) ? 32'(log_q[i]) : 32'hxxxxxxxx, 32'(exp_q[i]));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_ready", 32'(o_req_ready), 32'h0);
        chk("rst_start", 32'(o_tx_start), 32'h0);
        chk("rst_data", 32'(o_tx_data), 32'h0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(o_req_ready), 32'h0);
        chk("post_rst_start", 32'(o_tx_start), 32'h0);

        // Single requester, latency
        src_q[1].push_back({1'b1, 8'hA5});
        tick();
        chk("t1_grant_t0", 32'(o_grant), 32'h0);
        tick();
        chk("t1_grant_t1", 32'(o_grant), 32'b0010);
        chk("t1_ready_t1", 32'(o_req_ready), 32'b0010);
        tick();
        chk("t1_start_t2", 32'(o_tx_start), 32'h1);
        chk("t1_data_t2", 32'(o_tx_data), 32'hA5);
        wait_busy(1'b1, 5, "t1_busy_up");
        chk("t1_grant_held", 32'(o_grant), 32'b0010);
        chk("t1_data_stable", 32'(o_tx_data), 32'hA5);
        wait_grant(4'b0000, 40, "t1_release");
        chk("t1_busy_low_at_release", 32'(tx_busy), 32'h0);

        // Pointer is 2 after req1: req3 beats req0
        src_q[0].push_back({1'b1, 8'h33});
        src_q[3].push_back({1'b1, 8'h44});
        tick();
        tick();
        chk("t1_ptr_pick", 32'(o_grant), 32'b1000);
        wait_grant(4'b0000, 40, "t1b_rel3");
        tick();
        chk("t1b_next_owner", 32'(o_grant), 32'b0001);
        wait_grant(4'b0000, 40, "t1b_rel0");
        exp_q.push_back({4'b0010, 8'hA5});
        exp_q.push_back({4'b1000, 8'h44});
        exp_q.push_back({4'b0001, 8'h33});
        check_log("t1_log");

        // Contention after reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        src_q[0].push_back({1'b0, 8'h01});
        src_q[0].push_back({1'b0, 8'h02});
        src_q[0].push_back({1'b1, 8'h03});
        src_q[2].push_back({1'b0, 8'h11});
        src_q[2].push_back({1'b0, 8'h12});
        src_q[2].push_back({1'b1, 8'h13});
        wait_grant(4'b0001, 10, "t2_first_req0");
        wait_grant(4'b0000, 80, "t2_rel0");
        tick();
        chk("t2_gap_then_req2", 32'(o_grant), 32'b0100);
        wait_grant(4'b0000, 80, "t2_rel2");
        exp_q.push_back({4'b0001, 8'h01});
        exp_q.push_back({4'b0001, 8'h02});
        exp_q.push_back({4'b0001, 8'h03});
        exp_q.push_back({4'b0100, 8'h11});
        exp_q.push_back({4'b0100, 8'h12});
        exp_q.push_back({4'b0100, 8'h13});
        check_log("t2_log");

        // Burst limit of 4, pointer at 3
        for (int b = 1; b <= 6; b++) src_q[3].push_back({1'b0, 8'(8'h30 + b)});
        src_q[0].push_back({1'b1, 8'h0A});
        wait_grant(4'b1000, 10, "t3_req3");
        wait_grant(4'b0000, 120, "t3_burst_rel");
        tick();
        chk("t3_req0_next", 32'(o_grant), 32'b0001);
        wait_grant(4'b0000, 40, "t3_rel0");
        tick();
        chk("t3_req3_resume", 32'(o_grant), 32'b1000);
        wait_grant(4'b0000, 80, "t3_rel3");
        for (int b = 1; b <= 4; b++) exp_q.push_back({4'b1000, 8'(8'h30 + b)});
        exp_q.push_back({4'b0001, 8'h0A});
        exp_q.push_back({4'b1000, 8'h35});
        exp_q.push_back({4'b1000, 8'h36});
        check_log("t3_log");

        // Hold timeout of 5, pointer at 0
        src_q[1].push_back({1'b0, 8'h51});
        src_q[1].push_back({1'b0, 8'h52});
        src_q[2].push_back({1'b1, 8'h61});
        wait_grant(4'b0010, 10, "t4_req1");
        wait_busy(1'b1, 10, "t4_b1_up");
        wait_busy(1'b0, 20, "t4_b1_dn");
        wait_busy(1'b1, 10, "t4_b2_up");
        wait_busy(1'b0, 20, "t4_b2_dn");
        tick();
        chk("t4_send_grant", 32'(o_grant), 32'b0010);
        chk("t4_send_ready", 32'(o_req_ready), 32'h0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("t4_hold", 32'(o_grant), 32'b0010);
        end
        tick();
        chk("t4_revoked", 32'(o_grant), 32'h0);
        tick();
        chk("t4_req2_granted", 32'(o_grant), 32'b0100);
        wait_grant(4'b0000, 40, "t4_rel2");
        exp_q.push_back({4'b0010, 8'h51});
        exp_q.push_back({4'b0010, 8'h52});
        exp_q.push_back({4'b0100, 8'h61});
        check_log("t4_log");

        // Busy already high at grant, pointer at 3
        force_b = 1'b1;
        tick();
        src_q[0].push_back({1'b1, 8'h77});
        tick();
        tick();
        chk("t5_grant", 32'(o_grant), 32'b0001);
        chk("t5_ready_busy", 32'(o_req_ready), 32'h0);
        tick();
        chk("t5_ready_busy2", 32'(o_req_ready), 32'h0);
        force_b = 1'b0;
        tick();
        chk("t5_ready_free", 32'(o_req_ready), 32'b0001);
        tick();
        chk("t5_start", 32'(o_tx_start), 32'h1);
        chk("t5_data", 32'(o_tx_data), 32'h77);
        wait_grant(4'b0000, 40, "t5_rel");
        exp_q.push_back({4'b0001, 8'h77});
        check_log("t5_log");

        // Reset in WAIT_DONE with req2 pending
        src_q[1].push_back({1'b1, 8'h88});
        wait_grant(4'b0010, 10, "t6_req1");
        wait_busy(1'b1, 10, "t6_busy_up");
        tick();
        tick();
        src_q[2].push_back({1'b1, 8'h99});
        tick();
        tick();
        chk("t6_no_preempt", 32'(o_grant), 32'b0010);
        reset = 1'b1;
        tick();
        chk("t6_rst_grant", 32'(o_grant), 32'h0);
        chk("t6_rst_ready", 32'(o_req_ready), 32'h0);
        chk("t6_rst_start", 32'(o_tx_start), 32'h0);
        chk("t6_rst_data", 32'(o_tx_data), 32'h0);
        reset = 1'b0;
        tick();
        chk("t6_req2_grant", 32'(o_grant), 32'b0100);
        chk("t6_req2_ready", 32'(o_req_ready), 32'b0100);
        chk("t6_no_start", 32'(o_tx_start), 32'h0);
        wait_grant(4'b0000, 40, "t6_rel2");
        exp_q.push_back({4'b0010, 8'h88});
        exp_q.push_back({4'b0100, 8'h99});
        check_log("t6_log");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
